// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
// Optional build macro used by this block: DMEM_ARB_RR_EN (round-robin on contention).
package dmem_arb_pkg;

   // Owner of the read that is in flight in the RAM (data returns next cycle).
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CORE = 2'd1,
      OWN_AUX  = 2'd2
   } owner_t;

   localparam int AW_DEF       = 32;
   localparam int DW_DEF       = 32;
   localparam int BE_W         = DW_DEF / 8;
   localparam int MAX_WAIT_DEF = 8;

   // The core signals an access with any byte enable plus a read or write strobe.
   function automatic logic core_req_f(input logic any_en, input logic we, input logic re);
      return any_en & (we | re);
   endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the core MEM stage, the auxiliary requester, the RAM and the arbiter.
// slave  : arbiter view.  master : environment (core, aux requester, RAM) view.
interface dmem_port_arbiter_if
   import dmem_arb_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
);
   localparam int BW = DW / 8;

   // Core MEM-stage data bus
   logic [BW-1:0] core_en;
   logic          core_wea;
   logic          core_rea;
   logic [AW-1:0] core_addr;
   logic [DW-1:0] core_din;
   logic [DW-1:0] core_dout;
   logic          mem_hold;

   // Auxiliary requester (UART loader / debug DMA)
   logic          aux_req;
   logic          aux_we;
   logic [BW-1:0] aux_be;
   logic [AW-1:0] aux_addr;
   logic [DW-1:0] aux_wdata;
   logic          aux_gnt;
   logic          aux_rvalid;
   logic [DW-1:0] aux_rdata;

   // Single synchronous RAM port
   logic [BW-1:0] ram_en;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;

   modport slave (
      input  core_en, core_wea, core_rea, core_addr, core_din,
      input  aux_req, aux_we, aux_be, aux_addr, aux_wdata,
      input  ram_dout,
      output core_dout, mem_hold,
      output aux_gnt, aux_rvalid, aux_rdata,
      output ram_en, ram_we, ram_addr, ram_din
   );

   modport master (
      output core_en, core_wea, core_rea, core_addr, core_din,
      output aux_req, aux_we, aux_be, aux_addr, aux_wdata,
      output ram_dout,
      input  core_dout, mem_hold,
      input  aux_gnt, aux_rvalid, aux_rdata,
      input  ram_en, ram_we, ram_addr, ram_din
   );

endinterface

// File: rtl/dmem_arb_grant.sv
// Same-cycle grant between core and aux with a starvation counter for aux.
// Build macro DMEM_ARB_RR_EN: contested cycles alternate on a last-winner bit.
module dmem_arb_grant
   import dmem_arb_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic clk,
   input  logic Rst,
   input  logic core_req_i,
   input  logic aux_req_i,
   output logic core_win_o,
   output logic aux_win_o
);

   localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

   logic [7:0] wait_cnt_q, wait_cnt_d;
`ifdef DMEM_ARB_RR_EN
   // 1: aux won the last contested cycle. Resets to 1 so the first contest goes to the core.
   logic       last_aux_q, last_aux_d;
`endif

   // Grant decision; nothing is granted while reset is held.
   always_comb begin
      core_win_o = 1'b0;
      aux_win_o  = 1'b0;
      if (!Rst) begin
         if (core_req_i && aux_req_i) begin
            if (wait_cnt_q == WAIT_MAX) begin
               aux_win_o = 1'b1;
            end
`ifdef DMEM_ARB_RR_EN
            else if (!last_aux_q) begin
               aux_win_o = 1'b1;
            end
`endif
            else begin
               core_win_o = 1'b1;
            end
         end else if (core_req_i) begin
            core_win_o = 1'b1;
         end else if (aux_req_i) begin
            aux_win_o = 1'b1;
         end
      end
   end

   // Starvation counter next state: counts refused aux cycles, saturating at MAX_WAIT.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (aux_win_o || !aux_req_i) begin
         wait_cnt_d = '0;
      end else if (wait_cnt_q < WAIT_MAX) begin
         wait_cnt_d = wait_cnt_q + 8'd1;
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk) begin
      if (Rst) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end

`ifdef DMEM_ARB_RR_EN
   // Remember who won the most recent contested cycle.
   always_comb begin
      last_aux_d = last_aux_q;
      if (core_req_i && aux_req_i && !Rst) begin
         last_aux_d = aux_win_o;
      end
   end

   // Last-winner register.
   always_ff @(posedge clk) begin
      if (Rst) begin
         last_aux_q <= 1'b1;
      end else begin
         last_aux_q <= last_aux_d;
      end
   end
`endif

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one synchronous data-memory port between the core MEM stage and an aux requester.
// Muxes the winner onto the RAM, stalls the core when it loses, routes read data back.
// Build macro DMEM_ARB_RR_EN (handled in dmem_arb_grant): round-robin on contention.
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW       = AW_DEF,
   parameter int DW       = DW_DEF,
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic                clk,
   input  logic                Rst,
   dmem_port_arbiter_if.slave  bus
);

   localparam int BW = DW / 8;

   logic          core_req;
   logic          core_win;
   logic          aux_win;

   logic [BW-1:0] ram_en_d;
   logic          ram_we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] din_q, din_d;

   owner_t        rd_owner_q, rd_owner_d;
   logic [DW-1:0] core_q, core_d;

   assign core_req = core_req_f(|bus.core_en, bus.core_wea, bus.core_rea);

   dmem_arb_grant #(
      .MAX_WAIT (MAX_WAIT)
   ) u_grant (
      .clk        (clk),
      .Rst        (Rst),
      .core_req_i (core_req),
      .aux_req_i  (bus.aux_req),
      .core_win_o (core_win),
      .aux_win_o  (aux_win)
   );

   // RAM request mux; address and write data hold their last value when idle.
   always_comb begin
      ram_en_d = '0;
      ram_we_d = 1'b0;
      addr_d   = addr_q;
      din_d    = din_q;
      if (aux_win) begin
         ram_en_d = bus.aux_be;
         ram_we_d = bus.aux_we;
         addr_d   = bus.aux_addr;
         din_d    = bus.aux_wdata;
      end else if (core_win) begin
         ram_en_d = bus.core_en;
         ram_we_d = bus.core_wea;
         addr_d   = bus.core_addr;
         din_d    = bus.core_din;
      end
   end

   // Record which side owns the read issued this cycle; writes have no return.
   always_comb begin
      rd_owner_d = OWN_NONE;
      if (aux_win && !bus.aux_we) begin
         rd_owner_d = OWN_AUX;
      end else if (core_win && bus.core_rea && !bus.core_wea) begin
         rd_owner_d = OWN_CORE;
      end
   end

   // Capture returning core read data so the core sees it stable while stalled.
   always_comb begin
      core_d = core_q;
      if (rd_owner_q == OWN_CORE) begin
         core_d = bus.ram_dout;
      end
   end

   // Address/data hold, read owner and core return registers.
   always_ff @(posedge clk) begin
      if (Rst) begin
         addr_q     <= '0;
         din_q      <= '0;
         rd_owner_q <= OWN_NONE;
         core_q     <= '0;
      end else begin
         addr_q     <= addr_d;
         din_q      <= din_d;
         rd_owner_q <= rd_owner_d;
         core_q     <= core_d;
      end
   end

   // Outputs are forced to their reset values while Rst is held, including in-flight returns.
   assign bus.ram_en     = ram_en_d;
   assign bus.ram_we     = ram_we_d;
   assign bus.ram_addr   = Rst ? '0 : addr_d;
   assign bus.ram_din    = Rst ? '0 : din_d;
   assign bus.mem_hold   = core_req & ~core_win & ~Rst;
   assign bus.aux_gnt    = aux_win;
   assign bus.aux_rvalid = ~Rst & (rd_owner_q == OWN_AUX);
   assign bus.aux_rdata  = bus.aux_rvalid ? bus.ram_dout : '0;
   assign bus.core_dout  = Rst ? '0 : ((rd_owner_q == OWN_CORE) ? bus.ram_dout : core_q);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural synchronous RAM.
// Expectations follow DMEM_ARB_RR_EN when the bench is built with that macro.
module tb_dmem_port_arbiter;

   logic clk = 1'b0;
   logic Rst;
   logic preload;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] mem [256];

   dmem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

   dmem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(3)) dut (
      .clk (clk),
      .Rst (Rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Synchronous RAM: read data appears one cycle after issue.
   always @(posedge clk) begin
      if (preload) begin
         mem[8'h10] <= 32'hDEADBEEF;
         mem[8'h20] <= 32'h12345678;
         mem[8'h21] <= 32'hCAFEF00D;
      end else if (bus.ram_en != 4'h0) begin
         if (bus.ram_we) begin
            for (int b = 0; b < 4; b++) begin
               if (bus.ram_en[b]) mem[bus.ram_addr[9:2]][8*b +: 8] <= bus.ram_din[8*b +: 8];
            end
         end else begin
            bus.ram_dout <= mem[bus.ram_addr[9:2]];
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.core_en   = 4'h0;
      bus.core_wea  = 1'b0;
      bus.core_rea  = 1'b0;
      bus.core_addr = 32'h0;
      bus.core_din  = 32'h0;
      bus.aux_req   = 1'b0;
      bus.aux_we    = 1'b0;
      bus.aux_be    = 4'h0;
      bus.aux_addr  = 32'h0;
      bus.aux_wdata = 32'h0;
   endtask

   task automatic core_rd(input logic [31:0] a);
      bus.core_en   = 4'hF;
      bus.core_rea  = 1'b1;
      bus.core_wea  = 1'b0;
      bus.core_addr = a;
   endtask

   task automatic aux_rd(input logic [31:0] a, input logic [3:0] be);
      bus.aux_req  = 1'b1;
      bus.aux_we   = 1'b0;
      bus.aux_be   = be;
      bus.aux_addr = a;
   endtask

   initial begin
      logic exp_a;
      Rst     = 1'b1;
      preload = 1'b1;
      idle();
      step();
      preload = 1'b0;
      step();

      // Reset state
      chk("rst_mem_hold",   64'(bus.mem_hold),   64'h0);
      chk("rst_aux_gnt",    64'(bus.aux_gnt),    64'h0);
      chk("rst_aux_rvalid", 64'(bus.aux_rvalid), 64'h0);
      chk("rst_aux_rdata",  64'(bus.aux_rdata),  64'h0);
      chk("rst_core_dout",  64'(bus.core_dout),  64'h0);
      chk("rst_ram_en",     64'(bus.ram_en),     64'h0);
      chk("rst_ram_we",     64'(bus.ram_we),     64'h0);
      chk("rst_ram_addr",   64'(bus.ram_addr),   64'h0);
      chk("rst_ram_din",    64'(bus.ram_din),    64'h0);

      // Requests during reset are not granted
      core_rd(32'h40);
      aux_rd(32'h80, 4'hF);
      #1;
      chk("rstreq_ram_en",   64'(bus.ram_en),   64'h0);
      chk("rstreq_aux_gnt",  64'(bus.aux_gnt),  64'h0);
      chk("rstreq_mem_hold", 64'(bus.mem_hold), 64'h0);
      step();
      chk("rstreq_core_dout",  64'(bus.core_dout),  64'h0);
      chk("rstreq_aux_rvalid", 64'(bus.aux_rvalid), 64'h0);
      idle();
      Rst = 1'b0;

      // Core-only read of 0x40
      core_rd(32'h40);
      #1;
      chk("t1_ram_en",   64'(bus.ram_en),   64'hF);
      chk("t1_ram_we",   64'(bus.ram_we),   64'h0);
      chk("t1_ram_addr", 64'(bus.ram_addr), 64'h40);
      chk("t1_mem_hold", 64'(bus.mem_hold), 64'h0);
      chk("t1_aux_gnt",  64'(bus.aux_gnt),  64'h0);
      step();
      idle();
      #1;
      chk("t1_core_dout",  64'(bus.core_dout), 64'hDEADBEEF);
      chk("t1_mem_hold2",  64'(bus.mem_hold),  64'h0);
      step();
      chk("t1_core_dout_hold", 64'(bus.core_dout), 64'hDEADBEEF);

      // Simultaneous core and aux writes to 0x10: core first, aux next cycle
      bus.core_en   = 4'hF;
      bus.core_wea  = 1'b1;
      bus.core_addr = 32'h10;
      bus.core_din  = 32'h11111111;
      bus.aux_req   = 1'b1;
      bus.aux_we    = 1'b1;
      bus.aux_be    = 4'hF;
      bus.aux_addr  = 32'h10;
      bus.aux_wdata = 32'h22222222;
      #1;
      chk("t2_ram_we",   64'(bus.ram_we),   64'h1);
      chk("t2_ram_din",  64'(bus.ram_din),  64'h11111111);
      chk("t2_ram_en",   64'(bus.ram_en),   64'hF);
      chk("t2_aux_gnt0", 64'(bus.aux_gnt),  64'h0);
      chk("t2_hold0",    64'(bus.mem_hold), 64'h0);
      step();
      bus.core_en  = 4'h0;
      bus.core_wea = 1'b0;
      #1;
      chk("t2_aux_gnt1",  64'(bus.aux_gnt),  64'h1);
      chk("t2_ram_din1",  64'(bus.ram_din),  64'h22222222);
      chk("t2_ram_addr1", 64'(bus.ram_addr), 64'h10);
      chk("t2_hold1",     64'(bus.mem_hold), 64'h0);
      step();
      idle();
      #1;
      chk("t2_mem_word", 64'(mem[8'h04]), 64'h22222222);
      chk("t2_aux_gnt2", 64'(bus.aux_gnt), 64'h0);

      // Fresh reset so the contention test starts from a known last-winner state
      Rst = 1'b1;
      step();
      Rst = 1'b0;

      // Continuous contention for 20 cycles, MAX_WAIT = 3
      core_rd(32'h40);
      bus.aux_req   = 1'b1;
      bus.aux_we    = 1'b1;
      bus.aux_be    = 4'hF;
      bus.aux_addr  = 32'h20;
      bus.aux_wdata = 32'hA5A5A5A5;
      for (int i = 0; i < 20; i++) begin
         #1;
`ifdef DMEM_ARB_RR_EN
         exp_a = (i % 2) == 1;
`else
         exp_a = (i % 4) == 3;
`endif
         chk($sformatf("t3_aux_gnt_c%0d", i),  64'(bus.aux_gnt),  64'(exp_a));
         chk($sformatf("t3_mem_hold_c%0d", i), 64'(bus.mem_hold), 64'(exp_a));
         chk($sformatf("t3_ram_we_c%0d", i),   64'(bus.ram_we),   64'(exp_a));
         step();
      end
      idle();
      #1;
      chk("t3_wait_cnt", 64'(dut.u_grant.wait_cnt_q), 64'h0);
      chk("t3_core_dout", 64'(bus.core_dout), 64'hDEADBEEF);

      // Aux read 0x80 then core read 0x84 back-to-back
      aux_rd(32'h80, 4'hF);
      #1;
      chk("t4_aux_gnt",  64'(bus.aux_gnt),  64'h1);
      chk("t4_ram_addr", 64'(bus.ram_addr), 64'h80);
      chk("t4_ram_we",   64'(bus.ram_we),   64'h0);
      chk("t4_ram_en",   64'(bus.ram_en),   64'hF);
      step();
      bus.aux_req = 1'b0;
      core_rd(32'h84);
      #1;
      chk("t4_aux_rvalid", 64'(bus.aux_rvalid), 64'h1);
      chk("t4_aux_rdata",  64'(bus.aux_rdata),  64'h12345678);
      chk("t4_core_dout_old", 64'(bus.core_dout), 64'hDEADBEEF);
      chk("t4_ram_addr2",  64'(bus.ram_addr),   64'h84);
      chk("t4_mem_hold",   64'(bus.mem_hold),   64'h0);
      step();
      idle();
      #1;
      chk("t4_aux_rvalid_off", 64'(bus.aux_rvalid), 64'h0);
      chk("t4_aux_rdata_off",  64'(bus.aux_rdata),  64'h0);
      chk("t4_core_dout_new",  64'(bus.core_dout),  64'hCAFEF00D);
      step();
      chk("t4_core_dout_hold", 64'(bus.core_dout), 64'hCAFEF00D);

      // Reset asserted the cycle after an aux read issue
      aux_rd(32'h80, 4'hF);
      #1;
      chk("t5_aux_gnt", 64'(bus.aux_gnt), 64'h1);
      step();
      Rst = 1'b1;
      idle();
      #1;
      chk("t5_aux_rvalid", 64'(bus.aux_rvalid), 64'h0);
      chk("t5_aux_rdata",  64'(bus.aux_rdata),  64'h0);
      chk("t5_core_dout",  64'(bus.core_dout),  64'h0);
      chk("t5_ram_addr",   64'(bus.ram_addr),   64'h0);
      chk("t5_ram_din",    64'(bus.ram_din),    64'h0);
      chk("t5_ram_en",     64'(bus.ram_en),     64'h0);
      chk("t5_mem_hold",   64'(bus.mem_hold),   64'h0);
      step();
      Rst = 1'b0;
      #1;
      chk("t5_rvalid_after", 64'(bus.aux_rvalid), 64'h0);
      chk("t5_core_q_clr",   64'(bus.core_dout),  64'h0);
      core_rd(32'h40);
      #1;
      chk("t5_post_ram_en", 64'(bus.ram_en),   64'hF);
      chk("t5_post_hold",   64'(bus.mem_hold), 64'h0);
      step();
      idle();
      #1;
      chk("t5_post_core_dout", 64'(bus.core_dout), 64'hDEADBEEF);

      // Aux read with no byte enables is still granted and returns rvalid
      aux_rd(32'h80, 4'h0);
      #1;
      chk("t6_aux_gnt", 64'(bus.aux_gnt), 64'h1);
      chk("t6_ram_en",  64'(bus.ram_en),  64'h0);
      step();
      idle();
      #1;
      chk("t6_aux_rvalid", 64'(bus.aux_rvalid), 64'h1);
      step();
      chk("t6_aux_rvalid_off", 64'(bus.aux_rvalid), 64'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single synchronous data-memory port between the core's MEM-stage data bus and an auxiliary requester (UART loader / debug DMA).
- Issues one access per cycle to the RAM and routes read data back to the winner.
- Stalls the core pipeline via mem_hold when the core loses arbitration.
- Includes a starvation guard so the auxiliary port always makes progress.

Parameters:
- AW, 32, address width.
- DW, 32, data width; byte enables are DW/8 bits.
- MAX_WAIT, 8, cycles aux may be refused before it is forced to win; legal range 1..255.

Ports:
- clk  in  1  clock
- Rst  in  1  synchronous active-high reset
- core_en  in  4  core byte enables; nonzero means an active access
- core_wea  in  1  core write
- core_rea  in  1  core read
- core_addr  in  AW  core address
- core_din  in  DW  core write data
- core_dout  out  DW  core read data
- mem_hold  out  1  stall to the core pipeline
- aux_req  in  1  aux access request
- aux_we  in  1  aux write
- aux_be  in  4  aux byte enables
- aux_addr  in  AW  aux address
- aux_wdata  in  DW  aux write data
- aux_gnt  out  1  aux access issued this cycle
- aux_rvalid  out  1  aux read data valid
- aux_rdata  out  DW  aux read data
- ram_en  out  4  RAM byte enables
- ram_we  out  1  RAM write
- ram_addr  out  AW  RAM address
- ram_din  out  DW  RAM write data
- ram_dout  in  DW  RAM read data, valid 1 cycle after issue

Behaviour:
- Request detection:
  - core_req = (core_en != 0) & (core_wea | core_rea).
  - aux_req is used as driven.
- Grant (combinational, same cycle):
  - Only core_req: core wins.
  - Only aux_req: aux wins.
  - Both: core wins unless wait_cnt == MAX_WAIT, then aux wins.
- RAM outputs follow the winner's signals.
  - Aux: ram_en = aux_be; ram_we = aux_we.
  - Core: ram_en = core_en; ram_we = core_wea.
  - No winner: ram_en = 0, ram_we = 0; addr/din hold their last value (don't care).
- mem_hold = core_req & ~core_win, combinational. The core keeps its request stable while held.
- aux_gnt = aux_win, combinational. The aux requester drops or changes its request only after aux_gnt.
- wait_cnt (8 bit):
  - Cleared on aux grant or when aux_req = 0.
  - Otherwise increments while aux_req & ~aux_gnt; saturates at MAX_WAIT.
- Read return tracker: registered rd_owner in {NONE, CORE, AUX}, set at issue of any read.
  - Cycle after an aux read: aux_rvalid = 1 for one cycle, aux_rdata = ram_dout (passthrough).
  - Cycle after a core read: core_dout = ram_dout.
  - Otherwise core_dout returns the last captured core read value (core_q register), so the core sees stable data while stalled.
- Writes produce no return; rd_owner = NONE.
- Back-to-back accesses: one per cycle. Alternate-owner issue is allowed every cycle.
- Reset values: mem_hold 0, aux_gnt 0, aux_rvalid 0, aux_rdata 0, core_dout 0, ram_en 0, ram_we 0, ram_addr 0, ram_din 0, wait_cnt 0, rd_owner NONE.
  - Grant logic is gated off while Rst = 1, so all outputs hold their reset values during reset.
- Reset mid-read: a pending aux_rvalid is dropped; core_q is cleared.
- An aux read with aux_be = 0 is still granted; rvalid is returned, ram_en = 0, and data is don't-care.

Optional Feature:
- Macro DMEM_ARB_RR_EN.
- Defined: when both request, grant alternates on a 1-bit last_winner register (fairness round robin); the MAX_WAIT guard remains.
- Undefined: fixed core priority with the MAX_WAIT guard only.

Decomposition:
- Shared package dmem_arb_pkg:
  - typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_AUX} owner_t
  - widths AW_DEF/DW_DEF
  - localparam BE_W = DW/8
- One natural sub-module, dmem_arb_grant: pure combinational grant plus wait_cnt/last_winner registers. The top handles muxing and return routing.

Test Plan:
- Core-only read at 0x40 where RAM holds 0xDEADBEEF → ram_en = 4'hF on the issue cycle, core_dout = 0xDEADBEEF next cycle, mem_hold stays 0.
- Core write and aux write to 0x10 in the same cycle, MAX_WAIT = 8 → core issues first, aux_gnt the next cycle, mem_hold never asserted.
- Core requests every cycle for 20 cycles with aux_req held, MAX_WAIT = 3 → aux_gnt on cycle 4, mem_hold = 1 exactly that cycle, wait_cnt back to 0.
- Aux read 0x80 (RAM = 0x12345678) then core read 0x84 back-to-back → aux_rvalid pulses 1 cycle with 0x12345678; core_dout updates the following cycle; no cross-routing.
- Rst asserted the cycle after an aux read issue → aux_rvalid stays 0, all outputs zero, first post-reset core access proceeds normally.
- With DMEM_ARB_RR_EN, continuous dual requests → grants alternate C, A, C, A…; without it, C, C, C, A (MAX_WAIT = 3).
